eth_pkt_framer: RTL and testbench

//  Downstream neighbour of the Ethernet control stage. Takes its byte stream (12-byte parameter

---
 rtl/eth_pkt_pkg.sv | 38 +++
 rtl/eth_pkt_buf.sv | 27 ++
 rtl/eth_pkt_framer.sv | 171 +++++++++++++++++
 tb/tb_eth_pkt_framer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the Ethernet packet framer.
// The header layout lives here so the framer and any later consumer agree on it.
package eth_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HDR,
    PAYLOAD,
    DONE
  } framer_state_t;

  localparam logic [7:0] HDR_MAGIC  = 8'hA5;
  localparam int         HDR_BYTES  = 8;
  localparam int         FLAG_SOF   = 1;
  localparam int         FLAG_PARAM = 0;

  // Last header byte is the XOR of the seven before it.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  flags,
                                          input logic [7:0]  row,
                                          input logic [15:0] len,
                                          input logic [15:0] seq);
    logic [7:0] chk;
    chk = HDR_MAGIC ^ flags ^ row ^ len[15:8] ^ len[7:0] ^ seq[15:8] ^ seq[7:0];
    case (idx)
      3'd0:    return HDR_MAGIC;
      3'd1:    return flags;
      3'd2:    return row;
      3'd3:    return len[15:8];
      3'd4:    return len[7:0];
      3'd5:    return seq[15:8];
      3'd6:    return seq[7:0];
      default: return chk;
    endcase
  endfunction

endpackage

// File: rtl/eth_pkt_buf.sv
// Simple dual-port byte RAM: synchronous write, registered read.
// Out-of-range addresses are ignored on write and read back as zero.
module eth_pkt_buf #(
  parameter int DEPTH = 1440,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : 8'h00;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/eth_pkt_framer.sv
// Store-and-forward packet framer: buffers one payload, then streams an 8-byte
// application header followed by the payload over a byte valid/ready link.
module eth_pkt_framer import eth_pkt_pkg::*; #(
  parameter int MAX_PAYLOAD = 1440,
  parameter int PARAM_BYTES = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_raw_data,
  input  logic        i_raw_data_valid,
  input  logic [14:0] i_data_byte,
  input  logic [7:0]  i_row_number,
  input  logic        i_sof,
  input  logic        i_param_flag,
  output logic [7:0]  o_m_tdata,
  output logic        o_m_tvalid,
  input  logic        i_m_tready,
  output logic        o_m_tlast,
  output logic        o_eth_busy,
  output logic        o_packet_last,
  output logic        o_len_err,
  output logic        o_overflow
);

  localparam int          CW        = $clog2(MAX_PAYLOAD + 1);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] PARAM_LEN = 16'(PARAM_BYTES);

  framer_state_t state_q, state_d;
  logic [15:0]   len_q, len_d, seq_q, seq_d, len_in;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [2:0]    hdr_idx_q, hdr_idx_d;
  logic [7:0]    row_q, row_d, flags, rd_data;
  logic          sof_q, sof_d, param_q, param_d;
  logic          len_err_q, len_err_d, ovf_q, ovf_d, busy_q;
  logic          wr_en;
  logic [CW-1:0] wr_addr;

  eth_pkt_buf #(.DEPTH(MAX_PAYLOAD), .AW(CW)) u_buf (
    .clk_i     (i_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (i_raw_data),
    .rd_addr_i (rd_cnt_d),
    .rd_data_o (rd_data)
  );

  always_comb begin
    flags             = 8'h00;
    flags[FLAG_SOF]   = sof_q;
    flags[FLAG_PARAM] = param_q;
  end

  // The RAM is addressed with rd_cnt_d, so its registered output always shows
  // buf[rd_cnt_q]: payload streams without bubbles and holds steady on a stall.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    seq_d         = seq_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    hdr_idx_d     = hdr_idx_q;
    row_d         = row_q;
    sof_d         = sof_q;
    param_d       = param_q;
    len_err_d     = len_err_q;
    ovf_d         = ovf_q;
    wr_en         = 1'b0;
    wr_addr       = wr_cnt_q;
    o_m_tdata     = 8'h00;
    o_m_tvalid    = 1'b0;
    o_m_tlast     = 1'b0;
    o_packet_last = 1'b0;
    len_in        = i_param_flag ? PARAM_LEN : {1'b0, i_data_byte};

    case (state_q)
      IDLE: begin
        rd_cnt_d  = '0;
        hdr_idx_d = '0;
        if (i_raw_data_valid) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_cnt_d = CW'(1);
          row_d    = i_row_number;
          sof_d    = i_sof;
          param_d  = i_param_flag;
          if (len_in == 16'd0 || len_in > MAX_LEN) begin
            len_d     = MAX_LEN;
            len_err_d = 1'b1;
          end else begin
            len_d = len_in;
          end
          state_d = (len_d == 16'd1) ? HDR : CAPTURE;
        end
      end
      CAPTURE: begin
        if (i_raw_data_valid) begin
          if (16'(wr_cnt_q) < len_q) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (16'(wr_cnt_d) == len_q) state_d = HDR;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      HDR: begin
        o_m_tvalid = 1'b1;
        o_m_tdata  = hdr_byte(hdr_idx_q, flags, row_q, len_q, seq_q);
        if (i_m_tready) begin
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == 3'(HDR_BYTES - 1)) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        o_m_tvalid = 1'b1;
        o_m_tdata  = rd_data;
        o_m_tlast  = (16'(rd_cnt_q) == len_q - 16'd1);
        if (i_m_tready) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (o_m_tlast) state_d = DONE;
        end
      end
      DONE: begin
        o_packet_last = 1'b1;
        seq_d         = seq_q + 16'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_raw_data_valid && (state_q == HDR || state_q == PAYLOAD || state_q == DONE)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      seq_q     <= 16'd0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      hdr_idx_q <= '0;
      len_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      hdr_idx_q <= hdr_idx_d;
      len_err_q <= len_err_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Packet descriptor fields are only consumed outside IDLE, so they carry no reset.
  always_ff @(posedge i_clk) begin
    len_q   <= len_d;
    row_q   <= row_d;
    sof_q   <= sof_d;
    param_q <= param_d;
  end

  assign o_eth_busy = busy_q;
  assign o_len_err  = len_err_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_eth_pkt_framer.sv
// Directed bench for eth_pkt_framer: drives packets, collects the output stream
// and compares it with hand-computed headers and the known payload pattern.
module tb_eth_pkt_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  raw_data = 8'h00;
  logic        raw_valid = 1'b0;
  logic [14:0] data_byte = '0;
  logic [7:0]  row_num = 8'h00;
  logic        sof = 1'b0;
  logic        param = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        busy;
  logic        pkt_last;
  logic        len_err;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  bit         rxl_q[$];
  int         pl_cnt = 0;
  int         ready_mode = 0;
  bit         man_ready = 1'b0;
  int         hold = 0;
  bit         stall_q = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic       plast = 1'b0;

  always #5 clk = ~clk;

  eth_pkt_framer #(.MAX_PAYLOAD(1440), .PARAM_BYTES(12)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_raw_data       (raw_data),
    .i_raw_data_valid (raw_valid),
    .i_data_byte      (data_byte),
    .i_row_number     (row_num),
    .i_sof            (sof),
    .i_param_flag     (param),
    .o_m_tdata        (m_tdata),
    .o_m_tvalid       (m_tvalid),
    .i_m_tready       (m_tready),
    .o_m_tlast        (m_tlast),
    .o_eth_busy       (busy),
    .o_packet_last    (pkt_last),
    .o_len_err        (len_err),
    .o_overflow       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [7:0] seed);
    return 8'(i + (i >> 8)) + seed;
  endfunction

  // Sink: mode 0 always ready, 1 random, 2 manual, 3 stall 10 cycles on tlast.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom_range(0, 1) == 1);
        2: m_tready = man_ready;
        default: begin
          if (m_tlast && hold < 10) begin
            m_tready = 1'b0;
            hold++;
          end else begin
            m_tready = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q) begin
        check("hold_tvalid", m_tvalid, 1);
        check("hold_tdata", m_tdata, pdata);
        check("hold_tlast", m_tlast, plast);
      end
      if (m_tvalid && m_tready) begin
        rx_q.push_back(m_tdata);
        rxl_q.push_back(m_tlast);
      end
      if (pkt_last) pl_cnt++;
    end
    stall_q = rst_n && m_tvalid && !m_tready;
    pdata   = m_tdata;
    plast   = m_tlast;
  end

  task automatic send_pkt(input int n, input logic [14:0] dbyte, input logic [7:0] row,
                          input bit s, input bit p, input logic [7:0] seed,
                          input bit gaps, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        raw_valid = 1'b0;
      end
      @(posedge clk); #1;
      raw_valid = 1'b1;
      raw_data  = pat(i, seed);
      data_byte = dbyte;
      row_num   = row;
      sof       = s;
      param     = p;
      if (chk_busy && i == 0) begin
        @(negedge clk);
        check("busy_before_capture", busy, 0);
      end else if (chk_busy && i == 1) begin
        @(negedge clk);
        check("busy_rise", busy, 1);
      end
    end
    @(posedge clk); #1;
    raw_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (pkt_last) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, ok, 1);
    if (ok) begin
      check({tag, "_busy_in_done"}, busy, 1);
      @(negedge clk);
      check({tag, "_busy_fall"}, busy, 0);
      check({tag, "_pkt_last_pulse"}, pkt_last, 0);
    end
  endtask

  task automatic check_pkt(input string tag, input logic [63:0] hdr, input int len,
                           input logic [7:0] seed);
    int nl   = 0;
    int lpos = -1;
    check({tag, "_count"}, rx_q.size(), 8 + len);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      check($sformatf("%s_hdr%0d", tag, i), rx_q[i], hdr[63 - 8*i -: 8]);
    for (int i = 0; i < len && 8 + i < rx_q.size(); i++)
      check($sformatf("%s_pay%0d", tag, i), rx_q[8 + i], pat(i, seed));
    foreach (rxl_q[i]) begin
      if (rxl_q[i]) begin
        nl++;
        lpos = i;
      end
    end
    check({tag, "_tlast_cnt"}, nl, 1);
    check({tag, "_tlast_pos"}, lpos, 8 + len - 1);
    rx_q.delete();
    rxl_q.delete();
  endtask

  initial begin
    int pl0;
    bit found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_len_err", len_err, 0);
    check("rst_overflow", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Parameter block: data_byte ignored, length forced to 12.
    ready_mode = 0;
    pl0 = pl_cnt;
    send_pkt(12, 15'd96, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    wait_done("t1");
    repeat (3) @(negedge clk);
    check("t1_pkt_last_once", pl_cnt - pl0, 1);
    check_pkt("t1", 64'hA501_0000_0C00_00A8, 12, 8'h00);

    // Data row with random sink readiness and source gaps.
    ready_mode = 1;
    send_pkt(640, 15'd640, 8'h05, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0);
    wait_done("t2");
    check_pkt("t2", 64'hA502_0502_8000_0121, 640, 8'h40);

    // Stall ten cycles on the final byte.
    hold = 0;
    ready_mode = 3;
    send_pkt(16, 15'd16, 8'h09, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (m_tlast) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_tlast_seen", found, 1);
    for (int k = 0; k < 10; k++) begin
      check("t3_stall_tvalid", m_tvalid, 1);
      check("t3_stall_tlast", m_tlast, 1);
      check("t3_stall_tdata", m_tdata, pat(15, 8'h80));
      check("t3_stall_pkt_last", pkt_last, 0);
      if (k < 9) @(negedge clk);
    end
    wait_done("t3");
    ready_mode = 0;
    check_pkt("t3", 64'hA500_0900_1000_02BE, 16, 8'h80);

    // Bytes injected while the header is stalled.
    check("t5_ovf_before", ovf, 0);
    man_ready = 1'b0;
    ready_mode = 2;
    send_pkt(20, 15'd20, 8'h11, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      raw_valid = 1'b1;
      raw_data  = 8'hEE;
    end
    @(posedge clk); #1;
    raw_valid = 1'b0;
    @(negedge clk);
    check("t5_ovf_set", ovf, 1);
    check("t5_hdr_held_tvalid", m_tvalid, 1);
    check("t5_hdr_held_tdata", m_tdata, 8'hA5);
    ready_mode = 0;
    wait_done("t5a");
    check_pkt("t5a", 64'hA502_1100_1400_03A1, 20, 8'h20);
    send_pkt(8, 15'd8, 8'h22, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0);
    wait_done("t5b");
    check_pkt("t5b", 64'hA500_2200_0800_048B, 8, 8'h60);

    // Reset between tests clears seq and stickies.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_overflow", ovf, 0);
    check("rst2_busy", busy, 0);
    rst_n = 1'b1;

    // Oversized length: clamped to 1440, surplus bytes flagged.
    fork
      send_pkt(2000, 15'd2000, 8'h33, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      wait_done("t4");
    join
    check("t4_len_err", len_err, 1);
    check("t4_overflow", ovf, 1);
    check_pkt("t4", 64'hA500_3305_A000_0033, 1440, 8'h10);

    // Reset in the middle of the payload abandons the packet.
    send_pkt(200, 15'd200, 8'h44, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rx_q.size() >= 108) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_byte100", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_tvalid_drop", m_tvalid, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_len_err_clr", len_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_q.delete();
    rxl_q.delete();
    send_pkt(4, 15'd4, 8'h55, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0);
    wait_done("t6");
    check_pkt("t6", 64'hA502_5500_0400_00F6, 4, 8'hA0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
